// File: rtl/delay_line_probe_if.sv
// Measurement probe bus: system data in, delay-line Din/Q, and the control/status
// signals of one probe instance.
interface delay_line_probe_if #(
  parameter int DSIZE = 1,
  parameter int CSIZE = 7
);
  logic             start;
  logic [DSIZE-1:0] din_pass;
  logic [DSIZE-1:0] dout;
  logic [DSIZE-1:0] q_in;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CSIZE-1:0] meas_delay;

  modport master (
    output start, din_pass, q_in,
    input  dout, busy, done, timeout, meas_delay
  );

  modport slave (
    input  start, din_pass, q_in,
    output dout, busy, done, timeout, meas_delay
  );
endinterface

// File: rtl/delay_line_probe.sv
// Run-time tap-delay probe for a RAM-based shift register: forwards data while idle,
// otherwise flushes the line, injects a marker and times its return.
//
// state  | meaning
// IDLE   | dout follows din_pass, waiting for start
// FLUSH  | dout=0 until FLUSH_LEN consecutive zero q_in cycles (or MAX_WAIT cycles)
// INJECT | one-cycle all-ones marker on dout
// WAIT   | counting cycles until any q_in bit is set (or MAX_WAIT cycles)
// DONE   | one-cycle done pulse, meas_delay valid
module delay_line_probe #(
  parameter int DSIZE     = 1,
  parameter int WDEPTH    = 10,
  parameter int ASIZE     = $clog2(WDEPTH),
  parameter int FLUSH_LEN = 2**ASIZE + 2,
  parameter int MAX_WAIT  = 64,
  parameter int CSIZE     = $clog2(MAX_WAIT + 1)
) (
  input  logic               Clock,
  input  logic               Reset,
  delay_line_probe_if.slave  bus
);

  localparam int ZSIZE = $clog2(FLUSH_LEN + 1);
  localparam logic [ZSIZE-1:0] FLUSH_LEN_Z = ZSIZE'(FLUSH_LEN);
  localparam logic [CSIZE-1:0] MAX_WAIT_C  = CSIZE'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_INJECT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [ZSIZE-1:0] zcnt;
  logic [CSIZE-1:0] tcnt;
  logic             busy_r;
  logic             done_r;
  logic             timeout_r;
  logic [CSIZE-1:0] meas_r;

  logic [ZSIZE-1:0] zcnt_inc;
  logic [CSIZE-1:0] tcnt_inc;
  logic             q_zero;
  logic             marker;

  // Saturating increments: neither counter may wrap back into a valid range.
  assign zcnt_inc = (zcnt == FLUSH_LEN_Z) ? zcnt : zcnt + ZSIZE'(1);
  assign tcnt_inc = (tcnt == MAX_WAIT_C)  ? tcnt : tcnt + CSIZE'(1);
  assign marker   = |bus.q_in;
  assign q_zero   = ~marker;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      zcnt      <= '0;
      tcnt      <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      meas_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state     <= S_FLUSH;
            busy_r    <= 1'b1;
            zcnt      <= '0;
            tcnt      <= '0;
            timeout_r <= 1'b0;
          end
        end
        S_FLUSH: begin
          tcnt <= tcnt_inc;
          zcnt <= q_zero ? zcnt_inc : '0;
          // A clean line beats the time limit when both land on the same edge.
          if (q_zero && (zcnt_inc == FLUSH_LEN_Z)) begin
            state <= S_INJECT;
          end else if (tcnt_inc == MAX_WAIT_C) begin
            state     <= S_IDLE;
            busy_r    <= 1'b0;
            timeout_r <= 1'b1;
            meas_r    <= '0;
          end
        end
        S_INJECT: begin
          state <= S_WAIT;
          tcnt  <= CSIZE'(1);
        end
        S_WAIT: begin
          if (marker) begin
            state  <= S_DONE;
            done_r <= 1'b1;
            meas_r <= tcnt;
          end else if (tcnt == MAX_WAIT_C) begin
            state     <= S_IDLE;
            busy_r    <= 1'b0;
            timeout_r <= 1'b1;
            meas_r    <= '0;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  // dout is decoded from state so IDLE forwarding adds no latency.
  always_comb begin
    bus.dout = '0;
    case (state)
      S_IDLE:   bus.dout = bus.din_pass;
      S_INJECT: bus.dout = '1;
      default:  bus.dout = '0;
    endcase
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.timeout    = timeout_r;
  assign bus.meas_delay = meas_r;

endmodule

// File: doc/delay_line_probe.md
Name: delay_line_probe

Overview:
- Measurement stage that wraps the RAM-based shift register.
- Upstream: drives the shift register's data input. Downstream: watches its output.
- Idle: forwards the system data stream into the delay line with no added latency.
- On start: flushes the line, injects a one-cycle marker and counts clocks until the marker reappears, giving a run-time measurement of the programmed tap delay.

Parameters:
- DSIZE, 1, data width of the delay-line path.
- WDEPTH, 10, shift-register depth served.
- ASIZE, $clog2(WDEPTH), tap address width of the served line.
- FLUSH_LEN, 2**ASIZE+2, consecutive all-zero q_in cycles required before injection.
- MAX_WAIT, 64, cycle limit for the FLUSH phase and for the WAIT phase, each separately.
- CSIZE, $clog2(MAX_WAIT+1), width of counters and meas_delay.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  measurement request; sampled only in IDLE.
- din_pass  input  DSIZE  system data forwarded when IDLE.
- dout  output  DSIZE  to shift-register Din.
- q_in  input  DSIZE  from shift-register Q.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle pulse when a measurement completes successfully.
- timeout  output  1  sticky failure flag.
- meas_delay  output  CSIZE  last measured latency in cycles.

Behaviour:
- Clock is Clock. Reset is Reset, asynchronous, active-high.
- Reset: state=IDLE, counters=0, done=0, timeout=0, meas_delay=0, busy=0.
- Reset at any time, including mid-measurement, aborts immediately to these values.
- States: IDLE, FLUSH, INJECT, WAIT, DONE.
- dout is a combinational decode of the state register:
  - IDLE: din_pass.
  - INJECT: all ones (marker).
  - FLUSH, WAIT, DONE: all zeros.
- "Marker seen" means any bit of q_in is 1.
- IDLE:
  - start=1 -> FLUSH.
  - On the same edge: zcnt=0, tcnt=0, timeout cleared to 0.
  - meas_delay holds its old value until overwritten.
- FLUSH:
  - Every edge: tcnt+1.
  - q_in==0: zcnt+1. Otherwise zcnt=0.
  - The edge where zcnt would reach FLUSH_LEN -> INJECT.
  - Else if tcnt reaches MAX_WAIT -> IDLE with timeout=1 and meas_delay=0.
  - If both conditions hit on the same edge, FLUSH success wins.
- INJECT:
  - Lasts exactly one cycle. q_in is ignored in this cycle.
  - Next state WAIT, with cnt=1.
- WAIT:
  - Marker seen: meas_delay<=cnt, go to DONE.
  - Not seen and cnt==MAX_WAIT: timeout<=1, meas_delay<=0, go to IDLE.
  - Otherwise: cnt+1.
  - Detection takes priority over timeout on the same edge.
- Latency definition: if q_in(t)=dout(t-L) with 1<=L<=MAX_WAIT, then meas_delay=L.
  - L=0 (combinational path) is not measurable and results in timeout.
- DONE:
  - done=1 for exactly this one cycle, then IDLE.
  - start is ignored in DONE, as in every non-IDLE state.
- timeout stays high until the next accepted start or Reset.
- meas_delay changes only on the DONE-entry edge, on a timeout edge, or on Reset.
- Counters saturate and never wrap; MAX_WAIT bounds them.

Test Plan:
- Reset asserted for 100 ns -> busy=0, done=0, timeout=0, meas_delay=0; dout tracks din_pass, which the bench drives as an incrementing counter, with zero cycle offset.
- Bench ideal delay line of L=1, then L=5, then L=17 cycles, one start pulse each:
  - meas_delay=1, 5, 17 respectively.
  - done is high for exactly one cycle each time.
  - busy falls the cycle after done.
- dout wired straight to q_in (L=0) -> after FLUSH_LEN (18) cycles of FLUSH, INJECT, then 64 WAIT cycles -> timeout=1, meas_delay=0, done never pulses.
- q_in held at 1 -> FLUSH never completes -> timeout=1 after 64 FLUSH cycles; a following start with a healthy L=4 line clears timeout and yields meas_delay=4.
- start pulsed repeatedly during FLUSH, WAIT and DONE of an L=8 measurement -> single result meas_delay=8; no second measurement launches until a start is sampled in IDLE.
- Reset asserted mid-WAIT during an L=12 measurement -> same cycle: busy=0, timeout=0, meas_delay=0, dout=din_pass; a subsequent start yields meas_delay=12.
